// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Frame words arrive most-significant byte first (big-endian).
package loader_pkg;

    localparam int LOADER_WORD_W = 16;
    localparam int LOADER_BYTE_W = 8;

    // Byte lanes within an assembled word: first byte on the wire is the high lane.
    localparam int HI_BYTE_LSB = 8;
    localparam int LO_BYTE_LSB = 0;

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } loader_state_t;

    function automatic logic [LOADER_WORD_W-1:0] join_bytes(
        input logic [LOADER_BYTE_W-1:0] hi,
        input logic [LOADER_BYTE_W-1:0] lo
    );
        logic [LOADER_WORD_W-1:0] w;
        w = '0;
        w[HI_BYTE_LSB +: LOADER_BYTE_W] = hi;
        w[LO_BYTE_LSB +: LOADER_BYTE_W] = lo;
        return w;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// High-byte latch and registered block-RAM write port for the program loader.
// The latch is shared by the length field and the data words.
module loader_word_assembler
    import loader_pkg::*;
#(
    parameter logic [LOADER_WORD_W-1:0] BASE_ADDR = 16'h0000
)
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_latch_hi,
    input  logic                     i_issue_write,
    input  logic [LOADER_BYTE_W-1:0] i_byte,
    input  logic [LOADER_WORD_W-1:0] i_index,
    output logic [LOADER_WORD_W-1:0] o_word,
    output logic                     o_ram_we,
    output logic [LOADER_WORD_W-1:0] o_ram_write_addr,
    output logic [LOADER_WORD_W-1:0] o_ram_write_data
);

    logic [LOADER_BYTE_W-1:0] r_hi;
    logic                     r_ram_we;
    logic [LOADER_WORD_W-1:0] r_ram_write_addr;
    logic [LOADER_WORD_W-1:0] r_ram_write_data;
    logic [LOADER_WORD_W-1:0] w_word;

    assign w_word = join_bytes(r_hi, i_byte);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_hi <= '0;
        end else if (i_latch_hi) begin
            r_hi <= i_byte;
        end
    end

    // Address wraps modulo 2^16 by construction of the 16-bit adder.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ram_we         <= 1'b0;
            r_ram_write_addr <= BASE_ADDR;
            r_ram_write_data <= '0;
        end else begin
            r_ram_we <= i_issue_write;
            if (i_issue_write) begin
                r_ram_write_addr <= BASE_ADDR + i_index;
                r_ram_write_data <= w_word;
            end
        end
    end

    assign o_word           = w_word;
    assign o_ram_we         = r_ram_we;
    assign o_ram_write_addr = r_ram_write_addr;
    assign o_ram_write_data = r_ram_write_data;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: parses a length-prefixed big-endian byte stream into RAM words
// and holds the CPU until the image is complete. Checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
//
// state      | meaning
// ST_LEN_HI  | waiting for word-count high byte
// ST_LEN_LO  | waiting for word-count low byte, range check
// ST_DATA_HI | waiting for data word high byte
// ST_DATA_LO | waiting for data word low byte, issues RAM write
// ST_CHECK   | waiting for checksum byte (checksum build only)
// ST_DONE    | image loaded, CPU released
// ST_ERROR   | image rejected, CPU stays held
module program_loader
    import loader_pkg::*;
#(
    parameter logic [LOADER_WORD_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                       MAX_WORDS = 1024
)
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [LOADER_BYTE_W-1:0] i_byte_data,
    input  logic                     i_byte_valid,
    output logic                     o_byte_ready,
    output logic                     o_ram_we,
    output logic [LOADER_WORD_W-1:0] o_ram_write_addr,
    output logic [LOADER_WORD_W-1:0] o_ram_write_data,
    output logic                     o_cpu_hold,
    output logic                     o_load_done,
    output logic                     o_load_error
);

    localparam logic [LOADER_WORD_W-1:0] MAX_N = LOADER_WORD_W'(MAX_WORDS);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t ST_AFTER_DATA = ST_CHECK;
`else
    localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

    loader_state_t            r_state;
    loader_state_t            w_state_nxt;
    logic [LOADER_WORD_W-1:0] r_len;
    logic [LOADER_WORD_W-1:0] r_index;
    logic [LOADER_WORD_W-1:0] w_index_inc;
    logic [LOADER_WORD_W-1:0] w_word;
    logic                     w_ready;
    logic                     w_xfer;
    logic                     w_latch_hi;
    logic                     w_issue_write;
    logic                     w_load_len;

    assign w_ready     = (r_state != ST_DONE) && (r_state != ST_ERROR);
    assign w_xfer      = i_byte_valid && w_ready;
    assign w_index_inc = r_index + 1'b1;

    loader_word_assembler #(
        .BASE_ADDR(BASE_ADDR)
    ) u_asm (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_latch_hi      (w_latch_hi),
        .i_issue_write   (w_issue_write),
        .i_byte          (i_byte_data),
        .i_index         (r_index),
        .o_word          (w_word),
        .o_ram_we        (o_ram_we),
        .o_ram_write_addr(o_ram_write_addr),
        .o_ram_write_data(o_ram_write_data)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [LOADER_BYTE_W-1:0] r_xor;
    logic                     w_sum_ok;

    assign w_sum_ok = (i_byte_data == r_xor);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_xor <= '0;
        end else if (w_xfer && (r_state == ST_DATA_HI || r_state == ST_DATA_LO)) begin
            r_xor <= r_xor ^ i_byte_data;
        end
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_LEN_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_latch_hi    = 1'b0;
        w_issue_write = 1'b0;
        w_load_len    = 1'b0;
        case (r_state)
            ST_LEN_HI: begin
                if (w_xfer) begin
                    w_latch_hi  = 1'b1;
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_load_len = 1'b1;
                    if (w_word > MAX_N) begin
                        w_state_nxt = ST_ERROR;
                    end else if (w_word == '0) begin
                        w_state_nxt = ST_AFTER_DATA;
                    end else begin
                        w_state_nxt = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (w_xfer) begin
                    w_latch_hi  = 1'b1;
                    w_state_nxt = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (w_xfer) begin
                    w_issue_write = 1'b1;
                    w_state_nxt   = (w_index_inc == r_len) ? ST_AFTER_DATA : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (w_xfer) begin
                    w_state_nxt = w_sum_ok ? ST_DONE : ST_ERROR;
                end
`else
                w_state_nxt = ST_ERROR;
`endif
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_len   <= '0;
            r_index <= '0;
        end else begin
            if (w_load_len) begin
                r_len   <= w_word;
                r_index <= '0;
            end else if (w_issue_write) begin
                r_index <= w_index_inc;
            end
        end
    end

    assign o_byte_ready = w_ready;
    assign o_cpu_hold   = (r_state != ST_DONE);
    assign o_load_done  = (r_state == ST_DONE);
    assign o_load_error = (r_state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes queued at stimulus time,
// popped by a monitor on every ram_we pulse; status outputs checked directly.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bd = 8'h00;
    logic        bv = 1'b0;
    logic        o_byte_ready;
    logic        o_ram_we;
    logic [15:0] o_ram_write_addr;
    logic [15:0] o_ram_write_data;
    logic        o_cpu_hold;
    logic        o_load_done;
    logic        o_load_error;

    program_loader #(
        .BASE_ADDR(16'h0000),
        .MAX_WORDS(1024)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_byte_data     (bd),
        .i_byte_valid    (bv),
        .o_byte_ready    (o_byte_ready),
        .o_ram_we        (o_ram_we),
        .o_ram_write_addr(o_ram_write_addr),
        .o_ram_write_data(o_ram_write_data),
        .o_cpu_hold      (o_cpu_hold),
        .o_load_done     (o_load_done),
        .o_load_error    (o_load_error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_writes = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (o_ram_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         o_ram_write_addr, o_ram_write_data);
            end else begin
                e = exp_q.pop_front();
                check("ram_write", {o_ram_write_addr, o_ram_write_data}, e);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bv = 1'b1;
        bd = b;
        @(posedge clk);
        #1 bv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gappy);
        foreach (f[i]) begin
            if (gappy) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    bd = 8'($urandom);
                end
            end
            send(f[i]);
        end
    endtask

    task automatic pulse_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] f[$];
        int         w0;

        repeat (3) @(negedge clk);
        check("rst_ram_we", {31'd0, o_ram_we}, 32'd0);
        check("rst_addr", {16'd0, o_ram_write_addr}, 32'h0000);
        check("rst_data", {16'd0, o_ram_write_data}, 32'h0000);
        check("rst_cpu_hold", {31'd0, o_cpu_hold}, 32'd1);
        check("rst_load_done", {31'd0, o_load_done}, 32'd0);
        check("rst_load_error", {31'd0, o_load_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_byte_ready", {31'd0, o_byte_ready}, 32'd1);

        // Two-word frame, gap-free
        w0 = n_writes;
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'hABCD});
        f = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        f.push_back(8'h40);
`endif
        send_frame(f, 1'b0);
        @(negedge clk);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        check("last_write_with_release", {31'd0, o_ram_we}, 32'd1);
`endif
        check("t2_cpu_hold", {31'd0, o_cpu_hold}, 32'd0);
        check("t2_load_done", {31'd0, o_load_done}, 32'd1);
        check("t2_load_error", {31'd0, o_load_error}, 32'd0);
        check("t2_byte_ready", {31'd0, o_byte_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("t2_write_count", n_writes - w0, 32'd2);

        // Over-length frame
        pulse_reset();
        w0 = n_writes;
        send(8'h04);
        send(8'h01);
        check("ovr_load_error", {31'd0, o_load_error}, 32'd1);
        check("ovr_cpu_hold", {31'd0, o_cpu_hold}, 32'd1);
        check("ovr_byte_ready", {31'd0, o_byte_ready}, 32'd0);
        check("ovr_load_done", {31'd0, o_load_done}, 32'd0);
        send(8'h12);
        send(8'h34);
        repeat (3) @(negedge clk);
        check("ovr_error_sticky", {31'd0, o_load_error}, 32'd1);
        check("ovr_no_writes", n_writes - w0, 32'd0);

        // Exactly MAX_WORDS is accepted
        pulse_reset();
        send(8'h04);
        send(8'h00);
        check("max_not_error", {31'd0, o_load_error}, 32'd0);
        check("max_ready", {31'd0, o_byte_ready}, 32'd1);

        // Reset after word 3 of an 8-word frame, then a 1-word frame
        pulse_reset();
        w0 = n_writes;
        exp_q.push_back({16'h0000, 16'h0111});
        exp_q.push_back({16'h0001, 16'h0222});
        exp_q.push_back({16'h0002, 16'h0333});
        f = {8'h00, 8'h08, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33};
        send_frame(f, 1'b0);
        pulse_reset();
        check("midrst_hold", {31'd0, o_cpu_hold}, 32'd1);
        exp_q.push_back({16'h0000, 16'hBEEF});
        f = {8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        f.push_back(8'h51);
`endif
        send_frame(f, 1'b0);
        repeat (2) @(negedge clk);
        check("midrst_load_done", {31'd0, o_load_done}, 32'd1);
        check("midrst_write_count", n_writes - w0, 32'd4);

        // Same two-word frame with random valid gaps
        pulse_reset();
        w0 = n_writes;
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'hABCD});
        f = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        f.push_back(8'h40);
`endif
        send_frame(f, 1'b1);
        repeat (2) @(negedge clk);
        check("gap_load_done", {31'd0, o_load_done}, 32'd1);
        check("gap_write_count", n_writes - w0, 32'd2);

        // Zero-length frame
        pulse_reset();
        w0 = n_writes;
        f = {8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        send_frame(f, 1'b0);
        repeat (2) @(negedge clk);
        check("zero_load_done", {31'd0, o_load_done}, 32'd1);
        check("zero_cpu_hold", {31'd0, o_cpu_hold}, 32'd0);
        check("zero_no_writes", n_writes - w0, 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Good and bad checksum
        pulse_reset();
        exp_q.push_back({16'h0000, 16'h1234});
        f = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        send_frame(f, 1'b0);
        repeat (2) @(negedge clk);
        check("csum_ok_done", {31'd0, o_load_done}, 32'd1);
        check("csum_ok_error", {31'd0, o_load_error}, 32'd0);
        pulse_reset();
        exp_q.push_back({16'h0000, 16'h1234});
        f = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        send_frame(f, 1'b0);
        repeat (2) @(negedge clk);
        check("csum_bad_error", {31'd0, o_load_error}, 32'd1);
        check("csum_bad_hold", {31'd0, o_cpu_hold}, 32'd1);
        check("csum_bad_done", {31'd0, o_load_done}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
